// File: rtl/pb_debounce_pkg.sv
// rtl/pb_debounce_pkg.sv - shared defaults, pulse record and width helpers for the pushbutton debouncer
package pb_debounce_pkg;

  localparam int unsigned DEF_N_CH            = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
  localparam bit          DEF_ACTIVE_LOW      = 1'b1;
  localparam bit          DEF_REPEAT_EN       = 1'b1;
  localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;

  typedef struct packed {
    logic down;
    logic up;
    logic rpt;
  } pb_evt_t;

  // Bits needed to hold the values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pb_debounce_ch.sv
// rtl/pb_debounce_ch.sv - one pushbutton channel: synchronizer, stability counter, edge pulses, auto-repeat
module pb_debounce_ch
  import pb_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = DEF_ACTIVE_LOW,
  parameter bit          REPEAT_EN       = DEF_REPEAT_EN,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_raw,
  output logic pb_state,
  output logic pb_down,
  output logic pb_up,
  output logic pb_repeat
);

  localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned RW = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));

  localparam logic [DW-1:0] DB_LAST         = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RPT_DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
  localparam logic          IDLE_LEVEL      = ACTIVE_LOW;

  logic [1:0]    sync_q, sync_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          state_q, state_d;
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rpt_armed_q, rpt_armed_d;
  pb_evt_t       evt_q, evt_d;

  logic sample;
  logic toggle;
  logic rpt_fire;

  // XOR with the idle level turns the raw pin into "1 = pressed".
  assign sample = sync_q[1] ^ IDLE_LEVEL;

  always_comb begin
    sync_d   = {sync_q[0], pb_raw};
    db_cnt_d = '0;
    state_d  = state_q;
    toggle   = 1'b0;
    if (sample != state_q) begin
      if (db_cnt_q == DB_LAST) begin
        toggle  = 1'b1;
        state_d = ~state_q;
      end else begin
        db_cnt_d = db_cnt_q + DW'(1);
      end
    end
  end

  // The repeat timer only runs on a held channel that is not being released this edge,
  // so a release coinciding with a repeat slot yields pb_up alone.
  always_comb begin
    rpt_cnt_d   = '0;
    rpt_armed_d = 1'b0;
    rpt_fire    = 1'b0;
    if (REPEAT_EN && state_q && !toggle) begin
      rpt_armed_d = rpt_armed_q;
      rpt_cnt_d   = rpt_cnt_q + RW'(1);
      if (rpt_cnt_q == (rpt_armed_q ? RPT_PERIOD_LAST : RPT_DELAY_LAST)) begin
        rpt_fire    = 1'b1;
        rpt_cnt_d   = '0;
        rpt_armed_d = 1'b1;
      end
    end
  end

  always_comb begin
    evt_d.down = toggle & ~state_q;
    evt_d.up   = toggle & state_q;
    evt_d.rpt  = rpt_fire;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q      <= {2{IDLE_LEVEL}};
      db_cnt_q    <= '0;
      state_q     <= 1'b0;
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
      evt_q       <= '0;
    end else begin
      sync_q      <= sync_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_armed_q <= rpt_armed_d;
      evt_q       <= evt_d;
    end
  end

  assign pb_state  = state_q;
  assign pb_down   = evt_q.down;
  assign pb_up     = evt_q.up;
  assign pb_repeat = evt_q.rpt;

endmodule

// File: rtl/pb_debounce_multi.sv
// rtl/pb_debounce_multi.sv - N_CH independent debounced pushbuttons with press/release/repeat pulses
module pb_debounce_multi
  import pb_debounce_pkg::*;
#(
  parameter int unsigned N_CH            = DEF_N_CH,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = DEF_ACTIVE_LOW,
  parameter bit          REPEAT_EN       = DEF_REPEAT_EN,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] pb,
  output logic [N_CH-1:0] pb_state,
  output logic [N_CH-1:0] pb_down,
  output logic [N_CH-1:0] pb_up,
  output logic [N_CH-1:0] pb_repeat
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pb_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .REPEAT_EN       (REPEAT_EN),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .pb_raw    (pb[i]),
      .pb_state  (pb_state[i]),
      .pb_down   (pb_down[i]),
      .pb_up     (pb_up[i]),
      .pb_repeat (pb_repeat[i])
    );
  end

endmodule

// File: tb/tb_pb_debounce_multi.sv
// tb/tb_pb_debounce_multi.sv - scoreboard bench: two instances (repeat on / repeat off) driven by the same buttons
module tb_pb_debounce_multi;

  localparam int LAT = 6;   // DEBOUNCE_CYCLES + 2 edges from first sample to pb_state change
  localparam int RD  = 10;  // REPEAT_DELAY
  localparam int RP  = 3;   // REPEAT_PERIOD

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic [1:0] dn;
    logic [1:0] up;
    logic [1:0] rp;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] pb;
  logic [1:0] st0, dn0, up0, rp0;
  logic [1:0] st1, dn1, up1, rp1;

  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  ev_t q0[$];
  ev_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pb_debounce_multi #(
    .N_CH(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1), .REPEAT_EN(1),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .pb(pb),
    .pb_state(st0), .pb_down(dn0), .pb_up(up0), .pb_repeat(rp0)
  );

  pb_debounce_multi #(
    .N_CH(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1), .REPEAT_EN(0),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .pb(pb),
    .pb_state(st1), .pb_down(dn1), .pb_up(up1), .pb_repeat(rp1)
  );

  task automatic push_ev(input bit to1, input int c, input logic [1:0] st,
                         input logic [1:0] dn, input logic [1:0] up, input logic [1:0] rp);
    ev_t e;
    e.cyc = c; e.st = st; e.dn = dn; e.up = up; e.rp = rp;
    q0.push_back(e);
    if (to1) q1.push_back(e);
  endtask

  // Called just after a negedge; raw pin held pressed for len cycles, then released.
  task automatic press_release(input int ch, input int len);
    int c;
    int up_t;
    logic [1:0] m;
    m = '0;
    m[ch] = 1'b1;
    c = cyc;
    up_t = c + len + LAT;
    push_ev(1'b1, c + LAT, m, m, 2'b00, 2'b00);
    for (int t = c + LAT + RD; t < up_t; t += RP) push_ev(1'b0, t, m, 2'b00, 2'b00, m);
    push_ev(1'b1, up_t, 2'b00, 2'b00, m, 2'b00);
    pb[ch] = 1'b0;
    repeat (len) @(negedge clk);
    pb[ch] = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q0.size() + q1.size()) != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    total++;
    if ((q0.size() + q1.size()) != 0) begin
      bad++;
      $display("FAIL %s_missing: pending dut0=%0d dut1=%0d, want 0", name, q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    total++;
    if ({st0, dn0, up0, rp0, st1, dn1, up1, rp1} !== 16'h0000) begin
      bad++;
      $display("FAIL %s: outputs=%h, want 0000", name, {st0, dn0, up0, rp0, st1, dn1, up1, rp1});
    end
  endtask

  task automatic check_state(input string name, input logic [1:0] want);
    total++;
    if (st0 !== want || st1 !== want) begin
      bad++;
      $display("FAIL %s: pb_state dut0=%b dut1=%b, want %b", name, st0, st1, want);
    end
  endtask

  always @(negedge clk) begin : mon
    ev_t e;
    if ((dn0 | up0 | rp0) != 2'b00) begin
      total++;
      if (q0.size() == 0) begin
        bad++;
        $display("FAIL dut0_unexpected: cyc=%0d dn=%b up=%b rp=%b, want no pulse", cyc, dn0, up0, rp0);
      end else begin
        e = q0.pop_front();
        if (e.cyc != cyc || e.st !== st0 || e.dn !== dn0 || e.up !== up0 || e.rp !== rp0) begin
          bad++;
          $display("FAIL dut0_event: got cyc=%0d st=%b dn=%b up=%b rp=%b, want cyc=%0d st=%b dn=%b up=%b rp=%b",
                   cyc, st0, dn0, up0, rp0, e.cyc, e.st, e.dn, e.up, e.rp);
        end
      end
    end
    if ((dn1 | up1 | rp1) != 2'b00) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL dut1_unexpected: cyc=%0d dn=%b up=%b rp=%b, want no pulse", cyc, dn1, up1, rp1);
      end else begin
        e = q1.pop_front();
        if (e.cyc != cyc || e.st !== st1 || e.dn !== dn1 || e.up !== up1 || e.rp !== rp1) begin
          bad++;
          $display("FAIL dut1_event: got cyc=%0d st=%b dn=%b up=%b rp=%b, want cyc=%0d st=%b dn=%b up=%b rp=%b",
                   cyc, st1, dn1, up1, rp1, e.cyc, e.st, e.dn, e.up, e.rp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    int c;
    int r;
    rst_n = 1'b0;
    pb    = 2'b11;
    repeat (3) @(negedge clk);
    check_zero("reset_init");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_zero("idle_after_reset");

    // clean press on ch0, released before the first repeat slot
    press_release(0, 8);
    check_state("clean_hold", 2'b01);
    drain("clean");
    check_state("clean_released", 2'b00);

    // bounce: 0,1,0 at 2-cycle spacing, then settle low
    c = cyc;
    push_ev(1'b1, c + 4 + LAT, 2'b01, 2'b01, 2'b00, 2'b00);
    push_ev(1'b1, c + 12 + LAT, 2'b00, 2'b00, 2'b01, 2'b00);
    pb[0] = 1'b0;
    repeat (2) @(negedge clk);
    pb[0] = 1'b1;
    repeat (2) @(negedge clk);
    pb[0] = 1'b0;
    check_state("bounce_mid", 2'b00);
    repeat (8) @(negedge clk);
    pb[0] = 1'b1;
    drain("bounce");

    // auto-repeat; release lands on the edge of the next repeat slot
    press_release(0, 28);
    drain("repeat");

    // glitch one cycle shorter than the debounce window
    pb[0] = 1'b0;
    repeat (3) @(negedge clk);
    pb[0] = 1'b1;
    drain("glitch");
    check_state("glitch_state", 2'b00);

    // reset while ch1 is held
    c = cyc;
    push_ev(1'b1, c + LAT, 2'b10, 2'b10, 2'b00, 2'b00);
    pb[1] = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("reset_held_1");
    @(negedge clk);
    check_zero("reset_held_2");
    r = cyc;
    push_ev(1'b1, r + LAT, 2'b10, 2'b10, 2'b00, 2'b00);
    push_ev(1'b1, r + 8 + LAT, 2'b00, 2'b00, 2'b10, 2'b00);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    pb[1] = 1'b1;
    drain("reset_held");

    // long hold on ch1: dut0 repeats, dut1 must not
    press_release(1, 40);
    drain("long_hold");
    check_state("final_state", 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pb_debounce_multi.md
PB_DEBOUNCE_MULTI -- requirements
Module: pb_debounce_multi

Interface
REQ-001 SHALL provide parameter N_CH, default 4: number of independent pushbutton channels, legal range 1..32.
REQ-002 SHALL provide parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required to accept a change, at least 2.
REQ-003 SHALL provide parameter ACTIVE_LOW, default 1: 1 means raw input low = pressed; 0 means raw input high = pressed.
REQ-004 SHALL provide parameter REPEAT_EN, default 1: 1 enables auto-repeat pulses while held; 0 ties pb_repeat to 0.
REQ-005 SHALL provide parameter REPEAT_DELAY, default 25000000: held cycles before the first repeat pulse, at least 1.
REQ-006 SHALL provide parameter REPEAT_PERIOD, default 5000000: cycles between subsequent repeat pulses, at least 1.
REQ-007 SHALL have port clk, input, width 1: the single clock; all logic on posedge clk.
REQ-008 SHALL have port rst_n, input, width 1: synchronous, active-low reset.
REQ-009 SHALL have port pb, input, width N_CH: raw, glitchy pushbutton inputs, asynchronous to clk.
REQ-010 SHALL have port pb_state, output, width N_CH: debounced level, 1 = pressed.
REQ-011 SHALL have port pb_down, output, width N_CH: one-cycle pulse on an accepted press.
REQ-012 SHALL have port pb_up, output, width N_CH: one-cycle pulse on an accepted release.
REQ-013 SHALL have port pb_repeat, output, width N_CH: one-cycle auto-repeat pulse while held.

Function
REQ-014 SHALL pass each pb bit through a 2-flop synchronizer, then normalise polarity per ACTIVE_LOW, giving an active-high sample s[i].
REQ-015 SHALL give each channel its own stability counter, width $clog2(DEBOUNCE_CYCLES+1); channels fully independent.
REQ-016 SHALL clear the counter in any cycle where s[i] equals pb_state[i]; any glitch therefore restarts the count.
REQ-017 SHALL increment the counter while s[i] differs from pb_state[i]; when the count equals DEBOUNCE_CYCLES-1 and s[i] still differs, it SHALL toggle pb_state[i] and clear the counter on that edge.
REQ-018 SHALL make pb_state change exactly DEBOUNCE_CYCLES+2 clock edges after a clean, stable input transition is first sampled.
REQ-019 SHALL assert pb_down[i] (or pb_up[i]) as a registered pulse for exactly the first cycle in which pb_state[i] shows the new value 1 (or 0).
REQ-020 SHALL run a per-channel repeat counter only while pb_state[i]=1 and REPEAT_EN=1, counter width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1).
REQ-021 SHALL pulse pb_repeat[i] for one cycle REPEAT_DELAY cycles after the pb_down[i] cycle, then every REPEAT_PERIOD cycles, for as long as the channel stays held.
REQ-022 SHALL clear the repeat counter and suppress pb_repeat[i] from the cycle pb_up[i] asserts; a release that lands on the same edge as a repeat pulse SHALL produce pb_up only.
REQ-023 SHALL never assert pb_down and pb_repeat on the same channel in the same cycle; pb_down, pb_up and pb_repeat of a channel SHALL be mutually exclusive.
REQ-024 SHALL not wrap any counter: the stability counter stops at its terminal value by construction, and the repeat counter reloads instead of overflowing.

Reset
REQ-025 SHALL, while rst_n=0 at a clock edge, set the synchronizer flops to the released level, pb_state=0, all counters=0, and pb_down, pb_up and pb_repeat to 0.
REQ-026 SHALL, if a button is held through reset, emit pb_down DEBOUNCE_CYCLES+2 edges after rst_n rises, with no pb_up and no pb_repeat before it.
REQ-027 SHALL discard any partial count or repeat timing when reset asserts mid-operation, with no pulse in the cycle after reset.

Structure
REQ-028 SHALL place the default parameter constants and a function computing counter widths in package pb_debounce_pkg.
REQ-029 SHALL implement one channel as sub-module pb_debounce_ch and instantiate it N_CH times from a generate loop; the top level holds no per-channel logic.

Verification (bench parameters: N_CH=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, ACTIVE_LOW=1)
REQ-030 SHALL cover a clean press: pb[0] 1->0 and held -> pb_state[0] rises 6 edges later, pb_down[0]=1 for exactly that one cycle, pb[1] outputs stay 0.
REQ-031 SHALL cover a bounce: pb[0] toggles 0,1,0 at 2-cycle spacing, then settles low -> pb_state rises 6 edges after the final settle, with a single pb_down.
REQ-032 SHALL cover auto-repeat: hold pb[0] for 25 cycles after pb_down -> pb_repeat pulses at +10, +13, +16, +19, +22, +25; release -> one pb_up and no further repeats.
REQ-033 SHALL cover a short glitch: pb[0] low for 3 cycles, then high -> no change on pb_state, pb_down or pb_up.
REQ-034 SHALL cover reset while held: rst_n=0 for 2 cycles while pb[1] is held -> outputs 0 during reset, pb_down[1] 6 edges after rst_n rises.
REQ-035 SHALL cover REPEAT_EN=0: a 40-cycle hold -> pb_repeat stays 0 throughout, while pb_down and pb_up behave as in REQ-030.
